// File: rtl/register_ld_clr_inc_shr_pkg.sv
// Shared types and helpers for the clear/load/increment/shift-right data register.
package register_ld_clr_inc_shr_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLR,
        OP_LD,
        OP_INC,
        OP_SHR
    } op_e;

    // Fixed priority: clr > ld > inc > shr.
    function automatic op_e decode_op(input logic clr, input logic ld,
                                      input logic inc, input logic shr);
        op_e op;
        op = OP_NONE;
        if (clr) begin
            op = OP_CLR;
        end else if (ld) begin
            op = OP_LD;
        end else if (inc) begin
            op = OP_INC;
        end else if (shr) begin
            op = OP_SHR;
        end
        return op;
    endfunction

endpackage

// File: rtl/register_ld_clr_inc_shr_reg_next_value.sv
// Combinational next-state unit for the data register and its shift carry.
// REGISTER_LD_CLR_INC_SHR_ARITH_SHR_EN selects an arithmetic (MSB-replicating) shift right.
module reg_next_value
    import register_ld_clr_inc_shr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] data_out,
    input  logic             carry,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] next_data,
    output logic             next_carry
);

    logic fill;

`ifdef REGISTER_LD_CLR_INC_SHR_ARITH_SHR_EN
    assign fill = data_out[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    always_comb begin
        next_data  = data_out;
        next_carry = carry;
        unique case (op)
            OP_CLR: begin
                next_data  = '0;
                next_carry = 1'b0;
            end
            OP_LD:  next_data = data_in;
            OP_INC: next_data = data_out + WIDTH'(1);
            OP_SHR: begin
                next_data  = {fill, data_out[WIDTH-1:1]};
                next_carry = data_out[0];
            end
            default: begin
                next_data  = data_out;
                next_carry = carry;
            end
        endcase
    end

endmodule

// File: rtl/register_ld_clr_inc_shr.sv
// WIDTH-bit data register with clear, load, increment and shift-right, one op per clock.
// Define REGISTER_LD_CLR_INC_SHR_ARITH_SHR_EN for arithmetic shift right (default logical).
module register_ld_clr_inc_shr
    import register_ld_clr_inc_shr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             inc,
    input  logic             shr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             right_carry
);

    op_e              op;
    logic [WIDTH-1:0] next_data;
    logic             next_carry;

    assign op = decode_op(clr, ld, inc, shr);

    reg_next_value #(
        .WIDTH (WIDTH)
    ) u_next (
        .op         (op),
        .data_out   (data_out),
        .carry      (right_carry),
        .data_in    (data_in),
        .next_data  (next_data),
        .next_carry (next_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out    <= '0;
            right_carry <= 1'b0;
        end else begin
            data_out    <= next_data;
            right_carry <= next_carry;
        end
    end

endmodule

// File: tb/tb_register_ld_clr_inc_shr.sv
// Directed and randomized checks of register_ld_clr_inc_shr (WIDTH = 4).
module tb_register_ld_clr_inc_shr;

    logic       clk = 1'b0;
    logic       rst, clr, ld, inc, shr;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       right_carry;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_data;
    logic       m_carry;

    always #5 clk = ~clk;

    register_ld_clr_inc_shr #(
        .WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .ld          (ld),
        .inc         (inc),
        .shr         (shr),
        .data_in     (data_in),
        .data_out    (data_out),
        .right_carry (right_carry)
    );

    task automatic drive(input logic r, input logic c, input logic l, input logic i,
                         input logic s, input logic [3:0] d);
        rst = r; clr = c; ld = l; inc = i; shr = s; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp_d, input logic exp_c);
        n_checks++;
        assert (data_out === exp_d) else begin
            n_fail++;
            $error("FAIL %s data_out: got %h expected %h", tag, data_out, exp_d);
        end
        n_checks++;
        assert (right_carry === exp_c) else begin
            n_fail++;
            $error("FAIL %s right_carry: got %b expected %b", tag, right_carry, exp_c);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        check("reset_init", 4'h0, 1'b0);

        // Reset after preload, and reset overriding a load.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA);
        check("preload_a", 4'hA, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        check("reset_after_a", 4'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
        check("reset_over_ld", 4'h0, 1'b0);

        // Set carry, then clear must drop it while beating every other op.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1);
        check("ld_1", 4'h1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("shr_1", 4'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h9);
        check("ld_9", 4'h9, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h9);
        check("clr_all", 4'h0, 1'b0);

        // Increment wrap.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hE);
        check("ld_e", 4'hE, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        check("inc_f", 4'hF, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        check("inc_wrap", 4'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        check("inc_1", 4'h1, 1'b0);

        // Shift right of 1011.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1011);
        check("ld_b", 4'b1011, 1'b0);
`ifdef REGISTER_LD_CLR_INC_SHR_ARITH_SHR_EN
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("shr_a1", 4'b1101, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("shr_a2", 4'b1110, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("shr_a3", 4'b1111, 1'b0);
`else
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("shr_l1", 4'b0101, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("shr_l2", 4'b0010, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("shr_l3", 4'b0001, 1'b0);
`endif

        // ld > inc > shr, with carry set so holds are visible.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3);
        check("ld_3", 4'h3, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("shr_3", 4'h1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h7);
        check("ld_over_inc", 4'h7, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
        check("inc_over_shr", 4'h8, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
        check("idle_hold", 4'h8, 1'b1);

        // MSB fill on shift.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000);
        check("ld_8", 4'b1000, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
`ifdef REGISTER_LD_CLR_INC_SHR_ARITH_SHR_EN
        check("shr_fill", 4'b1100, 1'b0);
`else
        check("shr_fill", 4'b0100, 1'b0);
`endif

        // Random run against an independent reference model.
        m_data  = data_out;
        m_carry = right_carry;
        for (int k = 0; k < 100; k++) begin
            logic r, c, l, i, s;
            logic [3:0] d;
            r = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 7) == 0);
            l = $urandom_range(0, 3) == 0;
            i = $urandom_range(0, 1) == 1;
            s = $urandom_range(0, 1) == 1;
            d = 4'($urandom_range(0, 15));
            if (r || c) begin
                m_data  = 4'h0;
                m_carry = 1'b0;
            end else if (l) begin
                m_data = d;
            end else if (i) begin
                m_data = m_data + 4'h1;
            end else if (s) begin
                m_carry = m_data[0];
`ifdef REGISTER_LD_CLR_INC_SHR_ARITH_SHR_EN
                m_data  = {m_data[3], m_data[3:1]};
`else
                m_data  = {1'b0, m_data[3:1]};
`endif
            end
            drive(r, c, l, i, s, d);
            check("random", m_data, m_carry);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
